// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Desc    : Shared UART defaults, baud tick derivation and TX state encoding.
//           UART_TX_PARITY_EN adds the PARITY state to the enumeration.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  // Clocks per line bit; integer division truncates toward zero.
  function automatic int calc_baud_tick(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Desc   : DEPTH x 8 transmit buffer; pointers wrap modulo DEPTH, which must
//          be a power of two. Push while full and pop while empty are ignored.
// Rev    : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign full    = (r_count == c_FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Desc   : Buffered UART transmitter, 8N1 by default; defining
//          UART_TX_PARITY_EN inserts an even parity bit (8E1).
// Rev    : 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int                 c_BAUD_TICK = calc_baud_tick(CLK_FREQ, BAUD_RATE);
  localparam int                 c_CNT_W     = (c_BAUD_TICK > 1) ? $clog2(c_BAUD_TICK) : 1;
  localparam int                 c_FCNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_BAUD_TICK - 1);

  tx_state_t           r_state;
  logic [c_CNT_W-1:0]  r_baud_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_baud_last;
  logic [7:0]          w_rd_data;
  logic [c_FCNT_W-1:0] w_count;

  assign ready       = !w_full;
  assign w_push      = data_valid && ready;
  assign w_baud_last = (r_baud_cnt == c_BAUD_LAST);
  // Pop from IDLE, or in the final stop-bit clock so frames run back-to-back.
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data (data),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // tx is registered from the current state, so the line lags the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      busy <= (r_state != ST_IDLE) || (w_count != '0);

      if (r_state == ST_IDLE || w_baud_last) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + 1'b1;

      if (w_pop) r_shift <= w_rd_data;

      case (r_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (w_pop) r_state <= ST_START;
        end
        ST_START: begin
          tx <= 1'b0;
          if (w_baud_last) begin
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx <= r_shift[r_bit_idx];
          if (w_baud_last) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx <= ^r_shift;
          if (w_baud_last) r_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          tx <= 1'b1;
          if (w_baud_last) r_state <= w_pop ? ST_START : ST_IDLE;
        end
        default: begin
          tx      <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx
// Desc   : Self-checking bench for uart_tx against a frame-timeline model.
//          Honours UART_TX_PARITY_EN.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx;

  localparam int BT    = 434;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  uart_tx #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_valid (data_valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Model: FIFO contents plus the active frame (byte and the edge its start bit begins).
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       e_tx     = 1'b1;
  logic       e_ready  = 1'b1;
  logic       e_busy   = 1'b0;

  logic [7:0] b2b[5] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81};

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int e);
    bit accept;
    bit nonempty;
    accept   = data_valid && e_ready;
    nonempty = (q.size() != 0);
    e_busy   = m_active || nonempty;
    if (m_active && e == m_start + FL - 1) begin
      if (nonempty) begin
        m_byte  = q.pop_front();
        m_start = e + 1;
      end else begin
        m_active = 1'b0;
      end
    end else if (!m_active && nonempty) begin
      m_byte   = q.pop_front();
      m_start  = e + 1;
      m_active = 1'b1;
    end
    if (accept) q.push_back(data);
    e_ready = (q.size() < DEPTH);
    if (m_active && e >= m_start) e_tx = frame_bit(m_byte, (e - m_start) / BT);
    else                          e_tx = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_active = 1'b0;
        e_tx     = 1'b1;
        e_ready  = 1'b1;
        e_busy   = 1'b0;
      end else begin
        model_step(cyc + 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("tx", {7'd0, tx}, {7'd0, e_tx});
      chk("ready", {7'd0, ready}, {7'd0, e_ready});
      chk("busy", {7'd0, busy}, {7'd0, e_busy});
    end
  end

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Called at a falling edge; returns the rising edge on which the byte was taken.
  task automatic push(input logic [7:0] b, output int n);
    int guard;
    guard      = 0;
    data       = b;
    data_valid = 1'b1;
    while (ready !== 1'b1 && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    n = cyc + 1;
    if (guard >= 30000) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout at cycle %0d: got ready=%b, expected 1", cyc, ready);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    int n;
    int n1;
    int guard;
    logic [7:0] got;
    logic [10:0] a5_bits;
`ifdef UART_TX_PARITY_EN
    a5_bits = 11'b10100101010;
`else
    a5_bits = {1'b0, 10'b1101001010};
`endif

    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;

    // Quiet line after reset.
    repeat (10000) @(negedge clk);
    chk("idle_tx", {7'd0, tx}, 8'd1);
    chk("idle_ready", {7'd0, ready}, 8'd1);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // Single 0xA5 frame: latency, bit-centre samples, busy drop.
    @(negedge clk);
    push(8'hA5, n);
    wait_edge(n + 1);
    chk("a5_pre_fall", {7'd0, tx}, 8'd1);
    wait_edge(n + 2);
    chk("a5_fall", {7'd0, tx}, 8'd0);
    for (int k = 0; k < NB; k++) begin
      wait_edge(n + 2 + k * BT + BT / 2);
      chk("a5_bit", {7'd0, tx}, {7'd0, a5_bits[k]});
    end
    wait_edge(n + 1 + FL);
    chk("a5_busy_last", {7'd0, busy}, 8'd1);
    wait_edge(n + 2 + FL);
    chk("a5_busy_drop", {7'd0, busy}, 8'd0);

    // Back-to-back bytes: fill, contiguity and order.
    repeat (5) @(negedge clk);
    push(b2b[0], n1);
    for (int i = 1; i < 5; i++) push(b2b[i], n);
    chk("b2b_ready_full", {7'd0, ready}, 8'd0);
    for (int f = 0; f < 5; f++) begin
      if (f > 0) begin
        wait_edge(n1 + 1 + f * FL);
        chk("b2b_prev_stop", {7'd0, tx}, 8'd1);
      end
      wait_edge(n1 + 2 + f * FL + BT / 2);
      chk("b2b_start", {7'd0, tx}, 8'd0);
      got = 8'h00;
      for (int k = 1; k <= 8; k++) begin
        wait_edge(n1 + 2 + f * FL + k * BT + BT / 2);
        got[k-1] = tx;
      end
      chk("b2b_byte", got, b2b[f]);
    end
    wait_edge(n1 + 2 + 5 * FL);
    chk("b2b_busy_drop", {7'd0, busy}, 8'd0);

    // Reset 2000 clocks into a 0x3C frame.
    repeat (5) @(negedge clk);
    push(8'h3C, n);
    wait_edge(n + 2 + 2000);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 chk("rst_tx", {7'd0, tx}, 8'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    repeat (6000) @(negedge clk);
    chk("rst_quiet_tx", {7'd0, tx}, 8'd1);

`ifdef UART_TX_PARITY_EN
    // Parity bit values and 11-bit frame length.
    push(8'h07, n);
    wait_edge(n + 2 + 9 * BT + BT / 2);
    chk("par07_bit", {7'd0, tx}, 8'd1);
    wait_edge(n + 1 + 4774);
    chk("par07_busy_last", {7'd0, busy}, 8'd1);
    wait_edge(n + 2 + 4774);
    chk("par07_busy_drop", {7'd0, busy}, 8'd0);
    repeat (5) @(negedge clk);
    push(8'h03, n);
    wait_edge(n + 2 + 9 * BT + BT / 2);
    chk("par03_bit", {7'd0, tx}, 8'd0);
    wait_edge(n + 2 + 4774);
`endif

    // Random bytes with data_valid held high while the buffer is full.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'($urandom), n);
    chk("hold_ready_full", {7'd0, ready}, 8'd0);
    for (int i = 0; i < 5000; i++) begin
      data       = 8'($urandom);
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    guard = 0;
    while ((busy !== 1'b0 || e_busy) && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_done", {7'd0, busy}, 8'd0);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
